// File: rtl/multichannel_trigger_capture.sv
// Multichannel triggered capture: per-channel circular sample buffers with a programmable
// pre/post-trigger window, level or external trigger, and frozen-record random-access readout.
module multichannel_trigger_capture #(
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  DATA_W   = 16,
    parameter int unsigned  DEPTH    = 1024,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       ExtTrig,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [3:0]                 trig_src,
    input  logic                       trig_edge,
    input  logic [DATA_W-1:0]          trig_level,
    input  logic [ADDR_W-1:0]          pre_len,
    input  logic [ADDR_W:0]            post_len,
    input  logic [2:0]                 rd_chan,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [2:0]                 state,
    output logic                       done,
    output logic [ADDR_W-1:0]          trig_addr,
    output logic [15:0]                trig_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         wp_q, wp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         pre_q, pre_d;
    logic [CNT_W-1:0]          post_q, post_d;
    logic [3:0]                src_q, src_d;
    logic                      edge_q, edge_d;
    logic signed [DATA_W-1:0]  level_q, level_d;
    logic signed [DATA_W-1:0]  prev_q, prev_d;
    logic                      prev_vld_q, prev_vld_d;
    logic                      ext_prev_q;
    logic                      ext_seen_q, ext_seen_d;
    logic [ADDR_W-1:0]         trig_addr_q, trig_addr_d;
    logic [15:0]               trig_count_q, trig_count_d;
    logic                      done_q;
    logic [ADDR_W-1:0]         rd_ptr_q;
    logic [2:0]                rd_chan_q;
    logic [DATA_W-1:0]         rd_data_q;

    logic                      we_c;
    logic signed [DATA_W-1:0]  ch_in_c [CHANNELS];
    logic [DATA_W-1:0]         ch_rd_c [CHANNELS];
    logic signed [DATA_W-1:0]  sel_c;
    logic [DATA_W-1:0]         rd_mux_c;
    logic                      ext_edge_c, trig_c;
    logic [CNT_W-1:0]          room_c, post_min_c, post_clamp_c;

    // One buffer per channel, all sharing the write pointer
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];

        always_ff @(posedge Clk) begin
            if (we_c) mem_q[wp_q] <= in_data[g*DATA_W +: DATA_W];
        end

        assign ch_in_c[g] = in_data[g*DATA_W +: DATA_W];
        assign ch_rd_c[g] = mem_q[rd_ptr_q];
    end

    always_comb begin
        sel_c    = '0;
        rd_mux_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (int'(src_q) == k)     sel_c    = ch_in_c[k];
            if (int'(rd_chan_q) == k) rd_mux_c = ch_rd_c[k];
        end
    end

    // Window clamping applied to the raw config at arm time
    always_comb begin
        room_c       = CNT_W'(DEPTH) - CNT_W'(pre_len);
        post_min_c   = (post_len < room_c) ? post_len : room_c;
        post_clamp_c = (post_min_c == '0) ? CNT_W'(1) : post_min_c;
    end

    always_comb begin
        ext_edge_c = ExtTrig && !ext_prev_q;
        trig_c     = 1'b0;
        if (src_q == 4'hF) begin
            trig_c = ext_seen_q || ext_edge_c;
        end else if (32'(src_q) < CHANNELS && prev_vld_q) begin
            trig_c = edge_q ? (prev_q > level_q && sel_c <= level_q)
                            : (prev_q < level_q && sel_c >= level_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        post_d       = post_q;
        src_d        = src_q;
        edge_d       = edge_q;
        level_d      = level_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        ext_seen_d   = 1'b0;
        trig_addr_d  = trig_addr_q;
        trig_count_d = trig_count_q;
        we_c         = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        pre_d      = pre_len;
                        post_d     = post_clamp_c;
                        src_d      = trig_src;
                        edge_d     = trig_edge;
                        level_d    = trig_level;
                        cnt_d      = '0;
                        prev_vld_d = 1'b0;
                        state_d    = (pre_len == '0) ? S_ARMED : S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        we_c  = 1'b1;
                        wp_d  = wp_q + ADDR_W'(1);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(pre_q)) state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    // An ExtTrig edge between samples is held until the next valid sample
                    ext_seen_d = ext_seen_q || ext_edge_c;
                    if (in_valid) begin
                        we_c       = 1'b1;
                        wp_d       = wp_q + ADDR_W'(1);
                        prev_d     = sel_c;
                        prev_vld_d = 1'b1;
                        ext_seen_d = 1'b0;
                        if (trig_c) begin
                            trig_addr_d = wp_q;
                            cnt_d       = CNT_W'(1);
                            if (post_q == CNT_W'(1)) begin
                                state_d      = S_DONE;
                                trig_count_d = (trig_count_q == 16'hFFFF) ? trig_count_q
                                                                          : trig_count_q + 16'd1;
                            end else begin
                                state_d = S_CAPTURE;
                            end
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        we_c  = 1'b1;
                        wp_d  = wp_q + ADDR_W'(1);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == post_q) begin
                            state_d      = S_DONE;
                            trig_count_d = (trig_count_q == 16'hFFFF) ? trig_count_q
                                                                      : trig_count_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            wp_q         <= '0;
            cnt_q        <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            src_q        <= '0;
            edge_q       <= 1'b0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            ext_prev_q   <= 1'b0;
            ext_seen_q   <= 1'b0;
            trig_addr_q  <= '0;
            trig_count_q <= '0;
            done_q       <= 1'b0;
            rd_ptr_q     <= '0;
            rd_chan_q    <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            src_q        <= src_d;
            edge_q       <= edge_d;
            level_q      <= level_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            ext_prev_q   <= ExtTrig;
            ext_seen_q   <= ext_seen_d;
            trig_addr_q  <= trig_addr_d;
            trig_count_q <= trig_count_d;
            done_q       <= (state_d == S_DONE);
            // Two-stage readout: record index to physical address, then RAM read
            rd_ptr_q     <= trig_addr_q - pre_q + rd_addr;
            rd_chan_q    <= rd_chan;
            rd_data_q    <= rd_mux_c;
        end
    end

    assign rd_data    = rd_data_q;
    assign state      = state_q;
    assign done       = done_q;
    assign trig_addr  = trig_addr_q;
    assign trig_count = trig_count_q;

endmodule

// File: tb/tb_multichannel_trigger_capture.sv
// Bench for multichannel_trigger_capture: scenario tasks drive acquisitions; the expected
// record is queued as readout addresses are driven and compared as rd_data emerges.
module tb_multichannel_trigger_capture;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned CNT_W    = 11;

    logic                       Clk = 1'b0;
    logic                       Reset = 1'b0;
    logic [CHANNELS*DATA_W-1:0] in_data = '0;
    logic                       in_valid = 1'b0;
    logic                       ExtTrig = 1'b0;
    logic                       arm = 1'b0;
    logic                       abort = 1'b0;
    logic [3:0]                 trig_src = '0;
    logic                       trig_edge = 1'b0;
    logic [DATA_W-1:0]          trig_level = '0;
    logic [ADDR_W-1:0]          pre_len = '0;
    logic [ADDR_W:0]            post_len = '0;
    logic [2:0]                 rd_chan = '0;
    logic [ADDR_W-1:0]          rd_addr = '0;
    logic [DATA_W-1:0]          rd_data;
    logic [2:0]                 state;
    logic                       done;
    logic [ADDR_W-1:0]          trig_addr;
    logic [15:0]                trig_count;

    int          n_pass = 0;
    int          n_total = 0;
    int          exp_count = 0;
    logic [15:0] rec_q[$];
    logic [15:0] sb_q[$];

    multichannel_trigger_capture #(
        .CHANNELS(CHANNELS),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .ExtTrig   (ExtTrig),
        .arm       (arm),
        .abort     (abort),
        .trig_src  (trig_src),
        .trig_edge (trig_edge),
        .trig_level(trig_level),
        .pre_len   (pre_len),
        .post_len  (post_len),
        .rd_chan   (rd_chan),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .state     (state),
        .done      (done),
        .trig_addr (trig_addr),
        .trig_count(trig_count)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Channel k carries v*(k+1)
    task automatic set_sample(input int v, input bit vld);
        for (int k = 0; k < int'(CHANNELS); k++) in_data[k*DATA_W +: DATA_W] = 16'(v * (k + 1));
        in_valid = vld;
    endtask

    task automatic do_arm(input int pre, input int post, input int src, input bit edg, input int lvl);
        pre_len    = ADDR_W'(pre);
        post_len   = CNT_W'(post);
        trig_src   = 4'(src);
        trig_edge  = edg;
        trig_level = DATA_W'(lvl);
        in_valid   = 1'b0;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic readout(input int ch, input string tag);
        int          n;
        logic [15:0] exp_v;
        n       = rec_q.size();
        rd_chan = 3'(ch);
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                rd_addr = ADDR_W'(c);
                sb_q.push_back(rec_q[c]);
            end
            tick();
            if (c >= 1) begin
                exp_v = sb_q.pop_front();
                n_total++;
                if (rd_data !== exp_v)
                    $display("FAIL %s ch%0d addr %0d: got %0d expected %0d",
                             tag, ch, c - 1, $signed(rd_data), $signed(exp_v));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_total++; if (state !== 3'd0)   $display("FAIL reset_state: got %0d expected 0", state);   else n_pass++;
        n_total++; if (done !== 1'b0)    $display("FAIL reset_done: got %0b expected 0", done);     else n_pass++;
        n_total++; if (rd_data !== '0)   $display("FAIL reset_rd_data: got %0d expected 0", rd_data); else n_pass++;
        n_total++; if (trig_addr !== '0) $display("FAIL reset_trig_addr: got %0d expected 0", trig_addr); else n_pass++;
        n_total++; if (trig_count !== '0) $display("FAIL reset_trig_count: got %0d expected 0", trig_count); else n_pass++;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        int v_done = -1;
        do_arm(4, 8, 0, 1'b0, 100);
        n_total++; if (state !== 3'd1) $display("FAIL ramp_fill_state: got %0d expected 1", state); else n_pass++;
        // Latched config must not follow later port changes
        pre_len = 10'd9; post_len = 11'd2; trig_level = 16'd5;
        for (int v = 0; v < 300; v++) begin
            set_sample(v, 1'b1);
            tick();
            if (state == 3'd4) begin v_done = v; break; end
        end
        exp_count++;
        n_total++; if (v_done !== 107) $display("FAIL ramp_done_sample: got %0d expected 107", v_done); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL ramp_done_flag: got %0b expected 1", done); else n_pass++;
        n_total++; if (trig_addr !== 10'd100) $display("FAIL ramp_trig_addr: got %0d expected 100", trig_addr); else n_pass++;
        n_total++; if (trig_count !== 16'(exp_count)) $display("FAIL ramp_trig_count: got %0d expected %0d", trig_count, exp_count); else n_pass++;
        for (int v = 2000; v < 2005; v++) begin set_sample(v, 1'b1); tick(); end
        in_valid = 1'b0;
        rec_q.delete();
        for (int i = 0; i < 12; i++) rec_q.push_back(16'(96 + i));
        readout(0, "ramp");
        rec_q.delete();
        for (int i = 0; i < 12; i++) rec_q.push_back(16'(2 * (96 + i)));
        readout(1, "ramp");
    endtask

    task automatic test_ext_trigger();
        do_arm(0, 1, 15, 1'b0, 0);
        for (int v = 500; v < 503; v++) begin set_sample(v, 1'b1); tick(); end
        n_total++; if (state !== 3'd2) $display("FAIL ext_armed_state: got %0d expected 2", state); else n_pass++;
        in_valid = 1'b0; ExtTrig = 1'b1; tick();
        ExtTrig = 1'b0; tick();
        set_sample(777, 1'b1); tick();
        in_valid = 1'b0;
        exp_count++;
        n_total++; if (state !== 3'd4) $display("FAIL ext_done_state: got %0d expected 4", state); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL ext_done_flag: got %0b expected 1", done); else n_pass++;
        n_total++; if (trig_count !== 16'(exp_count)) $display("FAIL ext_trig_count: got %0d expected %0d", trig_count, exp_count); else n_pass++;
        rec_q.delete(); rec_q.push_back(16'd777);
        readout(0, "ext");
        rec_q.delete(); rec_q.push_back(16'(3 * 777));
        readout(2, "ext");
    endtask

    // Gaps carry a value that would trip the trigger if it were sampled
    task automatic run_gap_pass(input bit gappy, input string tag);
        int v_done = -1;
        int s = 40;
        do_arm(3, 5, 0, 1'b0, 50);
        for (int c = 0; c < 200; c++) begin
            if (gappy && c[0]) set_sample(1000, 1'b0);
            else begin set_sample(s, 1'b1); s++; end
            tick();
            if (state == 3'd4) begin v_done = s - 1; break; end
        end
        in_valid = 1'b0;
        exp_count++;
        n_total++; if (v_done !== 54) $display("FAIL %s_done_sample: got %0d expected 54", tag, v_done); else n_pass++;
        rec_q.delete();
        for (int i = 0; i < 8; i++) rec_q.push_back(16'(47 + i));
        readout(0, tag);
    endtask

    task automatic test_gaps();
        run_gap_pass(1'b0, "gap_ref");
        run_gap_pass(1'b1, "gap_half");
        n_total++; if (trig_count !== 16'(exp_count)) $display("FAIL gap_trig_count: got %0d expected %0d", trig_count, exp_count); else n_pass++;
    endtask

    task automatic test_falling_signed();
        int seq [10] = '{5, 0, -5, 100, 20, -9, -10, -11, -12, -13};
        int i_done = -1;
        do_arm(2, 3, 1, 1'b1, -10);
        for (int i = 0; i < 10; i++) begin
            in_data = '0;
            in_data[DATA_W +: DATA_W] = 16'(seq[i]);
            in_valid = 1'b1;
            tick();
            if (state == 3'd4) begin i_done = i; break; end
        end
        in_valid = 1'b0;
        exp_count++;
        n_total++; if (i_done !== 8) $display("FAIL fall_done_index: got %0d expected 8", i_done); else n_pass++;
        rec_q.delete();
        rec_q.push_back(16'(20));  rec_q.push_back(16'(-9));  rec_q.push_back(16'(-10));
        rec_q.push_back(16'(-11)); rec_q.push_back(16'(-12));
        readout(1, "fall");
    endtask

    task automatic test_wrap_clamp();
        int v_done = -1;
        do_arm(1023, 1024, 0, 1'b0, 1500);
        for (int v = 0; v < 2100; v++) begin
            set_sample(v, 1'b1);
            tick();
            if (state == 3'd4) begin v_done = v; break; end
        end
        in_valid = 1'b0;
        exp_count++;
        n_total++; if (v_done !== 1500) $display("FAIL wrap_done_sample: got %0d expected 1500", v_done); else n_pass++;
        n_total++; if (trig_count !== 16'(exp_count)) $display("FAIL wrap_trig_count: got %0d expected %0d", trig_count, exp_count); else n_pass++;
        rec_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) rec_q.push_back(16'(477 + i));
        readout(0, "wrap");
    endtask

    task automatic test_abort_fill();
        do_arm(10, 4, 0, 1'b0, 5);
        for (int v = 0; v < 10; v++) begin
            set_sample(v, 1'b1);
            tick();
            if (v == 6) begin
                n_total++; if (state !== 3'd1) $display("FAIL fill_ignore_trig: got %0d expected 1", state); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_total++; if (state !== 3'd2) $display("FAIL fill_to_armed: got %0d expected 2", state); else n_pass++;
        abort = 1'b1; arm = 1'b1; tick();
        abort = 1'b0; arm = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL abort_arm_state: got %0d expected 0", state); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %0b expected 0", done); else n_pass++;
        tick();
        n_total++; if (state !== 3'd0) $display("FAIL abort_stays_idle: got %0d expected 0", state); else n_pass++;
        n_total++; if (trig_count !== 16'(exp_count)) $display("FAIL abort_trig_count: got %0d expected %0d", trig_count, exp_count); else n_pass++;
    endtask

    task automatic test_bad_src();
        do_arm(0, 2, 6, 1'b0, 10);
        for (int v = 0; v < 30; v++) begin set_sample(v, 1'b1); tick(); end
        in_valid = 1'b0;
        n_total++; if (state !== 3'd2) $display("FAIL bad_src_no_trig: got %0d expected 2", state); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL bad_src_abort: got %0d expected 0", state); else n_pass++;
    endtask

    task automatic test_reset_mid_capture();
        do_arm(0, 50, 0, 1'b0, 3);
        for (int v = 0; v < 10; v++) begin set_sample(v, 1'b1); tick(); end
        n_total++; if (state !== 3'd3) $display("FAIL mid_capture_state: got %0d expected 3", state); else n_pass++;
        #2 Reset = 1'b0;
        #1;
        n_total++; if (state !== 3'd0) $display("FAIL async_reset_state: got %0d expected 0", state); else n_pass++;
        n_total++; if (trig_count !== 16'd0) $display("FAIL async_reset_count: got %0d expected 0", trig_count); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL async_reset_done: got %0b expected 0", done); else n_pass++;
        in_valid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ext_trigger();
        test_gaps();
        test_falling_signed();
        test_wrap_clamp();
        test_abort_fill();
        test_bad_src();
        test_reset_mid_capture();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
